mul_scheduler: RTL and testbench

MUL_SCHEDULER -- requirements
Module: mul_scheduler

---
 rtl/mul_scheduler.sv | 126 ++++++++++++
 tb/tb_mul_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_scheduler.sv
// Two-requester front end for one shared iterative shift-add multiplier.
// Requests are arbitrated round-robin, and one multiplier bit is consumed per BUSY cycle.
module mul_scheduler #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic               res_valid,
    output logic               res_id,
    output logic [2*WIDTH-1:0] res,
    input  logic               res_ready
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 ptr_q, ptr_d;
    logic                 id_q, id_d;
    logic                 res_id_q, res_id_d;
    logic [2*WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 gnt0, gnt1;
    logic [2*WIDTH-1:0]   sum;

    // Partial-product step: the multiplier is shifted right, so bit 0 is always the current bit.
    assign sum = acc_q + (b_q[0] ? a_q : '0);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        res_id_d = res_id_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        gnt0     = 1'b0;
        gnt1     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Ready is suppressed while reset is held so no output shows activity then.
                gnt0 = reset && req0_valid && (!req1_valid || !ptr_q);
                gnt1 = reset && req1_valid && (!req0_valid ||  ptr_q);
                if (gnt0 || gnt1) begin
                    state_d = BUSY;
                    a_d     = {{WIDTH{1'b0}}, (gnt1 ? req1_a : req0_a)};
                    b_d     = gnt1 ? req1_b : req0_b;
                    id_d    = gnt1;
                    ptr_d   = gnt0;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                acc_d = sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    res_d    = sum;
                    res_id_d = id_q;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            id_q     <= 1'b0;
            res_id_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            res_id_q <= res_id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign res_valid  = (state_q == DONE);
    assign res_id     = res_id_q;
    assign res        = res_q;

endmodule

// File: tb/tb_mul_scheduler.sv
// Scoreboard bench for mul_scheduler: the driver predicts grants and pushes expected products,
// and a separate monitor pops them whenever a result is handed over.
module tb_mul_scheduler;

    localparam int W = 16;

    logic           clk;
    logic           reset;
    logic           req0_valid, req1_valid;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           req0_ready, req1_ready;
    logic           res_valid, res_id, res_ready;
    logic [2*W-1:0] res;

    mul_scheduler #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_ready(req1_ready),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res       (res),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic           id;
        logic [2*W-1:0] prod;
        int             acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    logic id_log[$];
    int   checks = 0;
    int   failures = 0;

    // Abstract engine model: free, or counting down the multiply, or holding a result.
    bit m_free = 1'b1;
    bit m_ptr  = 1'b0;
    int m_t    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input bit rr);
        bit   g0, g1;
        exp_t e;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        res_ready  = rr;
        #1;
        g0 = m_free && v0 && (!v1 || !m_ptr);
        g1 = m_free && v1 && (!v0 ||  m_ptr);
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("res_valid", res_valid, (!m_free && m_t == 0));
        if (g0 || g1) begin
            e.id      = g1;
            e.prod    = g1 ? ({{W{1'b0}}, a1} * {{W{1'b0}}, b1})
                           : ({{W{1'b0}}, a0} * {{W{1'b0}}, b0});
            e.acc_cyc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (m_free) begin
            if (g0 || g1) begin
                m_free = 1'b0;
                m_t    = W;
                m_ptr  = g0;
            end
        end else if (m_t > 0) begin
            m_t = m_t - 1;
        end else if (rr) begin
            m_free = 1'b1;
        end
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, rr);
    endtask

    task automatic async_reset_pulse();
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #3;
        reset = 1'b0;
        exp_q.delete();
        m_free = 1'b1;
        m_ptr  = 1'b0;
        m_t    = 0;
        #1;
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res", res, '0);
        chk("rst_res_id", res_id, 1'b0);
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Monitor: checks every handed-over result against the oldest outstanding expectation.
    initial begin : monitor
        bit             seen;
        int             rise;
        logic [2*W-1:0] hres;
        logic           hid;
        exp_t           e;
        seen = 1'b0;
        rise = 0;
        hres = '0;
        hid  = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                seen = 1'b0;
            end else if (res_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    rise = cyc;
                    hres = res;
                    hid  = res_id;
                end else begin
                    chk("res_stable", res, hres);
                    chk("res_id_stable", res_id, hid);
                end
                if (res_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result: got res=%0h id=%0d with no request outstanding", res, res_id);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res", res, e.prod);
                        chk("res_id", res_id, e.id);
                        chk("latency", rise - e.acc_cyc, W);
                        id_log.push_back(res_id);
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin : driver
        int n_before;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        res_ready = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("init_res_valid", res_valid, 1'b0);
        chk("init_res", res, '0);
        chk("init_res_id", res_id, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single request, then boundary operands
        step(1'b1, 16'd3, 16'd5, 1'b0, '0, '0, 1'b1);
        idle(20, 1'b1);
        step(1'b0, '0, '0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        idle(20, 1'b1);
        step(1'b1, 16'h0000, 16'h1234, 1'b0, '0, '0, 1'b1);
        idle(20, 1'b1);
        step(1'b0, '0, '0, 1'b1, 16'hABCD, 16'h0000, 1'b1);
        idle(20, 1'b1);

        // Back-pressure with both requesters knocking throughout
        step(1'b1, 16'h00C3, 16'h0101, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < W + 10; i++)
            step(1'b1, 16'h1111, 16'h2222, 1'b1, 16'h3333, 16'h4444, 1'b0);
        idle(40, 1'b1);

        // Reset in the middle of a multiply
        step(1'b1, 16'h0102, 16'h0304, 1'b0, '0, '0, 1'b1);
        idle(8, 1'b1);
        async_reset_pulse();
        step(1'b1, 16'd7, 16'd9, 1'b0, '0, '0, 1'b1);
        idle(20, 1'b1);

        // Requester 1 valid only while the engine is busy
        n_before = id_log.size();
        step(1'b1, 16'd11, 16'd13, 1'b0, '0, '0, 1'b1);
        idle(3, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 16'd5, 16'd6, 1'b1);
        idle(20, 1'b1);
        chk("withdrawn_results", id_log.size() - n_before, 1);
        chk("withdrawn_pending", exp_q.size(), 0);

        // Contention from reset: grants must alternate starting with requester 0
        async_reset_pulse();
        id_log.delete();
        for (int i = 0; i < 4 * (W + 2); i++)
            step(1'b1, rnd_op(), rnd_op(), 1'b1, rnd_op(), rnd_op(), 1'b1);
        idle(25, 1'b1);
        chk("contention_count", (id_log.size() >= 4), 1'b1);
        if (id_log.size() >= 4) begin
            chk("grant0", id_log[0], 1'b0);
            chk("grant1", id_log[1], 1'b1);
            chk("grant2", id_log[2], 1'b0);
            chk("grant3", id_log[3], 1'b1);
        end

        // Randomized traffic
        for (int i = 0; i < 800; i++)
            step(($urandom_range(0, 2) != 0), rnd_op(), rnd_op(),
                 ($urandom_range(0, 2) != 0), rnd_op(), rnd_op(),
                 ($urandom_range(0, 3) != 0));
        idle(40, 1'b1);
        chk("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
